// File: rtl/tc_scan_pkg.sv
// Shared state encoding and counter widths for the scan sequencer slice.
package tc_scan_pkg;

    localparam int IDX_W   = 3;
    localparam int DWELL_W = 8;
    localparam int BLANK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/tc_dwell_timer.sv
// Loadable down-counter; tc is high while the count sits at zero and the count never wraps.
module tc_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/tc_scan_sequencer.sv
// Steps a 3-to-8 decoder select through indices 0..last with per-index dwell and optional blanking.
module tc_scan_sequencer
    import tc_scan_pkg::*;
#(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [IDX_W-1:0]   last,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BLANK_W-1:0] blank,
    output logic               sel0,
    output logic               sel1,
    output logic               sel2,
    output logic               dis,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    localparam int unused_uuid   = UUID;
    localparam int unused_name_w = $bits(NAME);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [BLANK_W-1:0] blank_q;
    logic               cont_q;

    logic               start_ok;
    logic               at_last;
    logic [IDX_W-1:0]   next_idx;
    logic               dwell_tc;
    logic               blank_tc;
    logic               dwell_load;
    logic [DWELL_W-1:0] dwell_load_val;
    logic               blank_load;

    assign start_ok = (state == ST_IDLE) && start && !stop;
    assign at_last  = (idx == last_q);
    assign next_idx = at_last ? '0 : idx + 1'b1;

    // Dwell reloads on every entry to ACTIVE; the first load must use the live input since capture happens on the same edge.
    assign dwell_load     = start_ok || ((state == ST_ACTIVE) && dwell_tc) || ((state == ST_BLANK) && blank_tc);
    assign dwell_load_val = start_ok ? dwell : dwell_q;
    assign blank_load     = (state == ST_ACTIVE) && dwell_tc;

    tc_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .en       (state == ST_ACTIVE),
        .load_val (dwell_load_val),
        .tc       (dwell_tc)
    );

    tc_dwell_timer #(.W(BLANK_W)) u_blank (
        .clk      (clk),
        .rst      (rst),
        .load     (blank_load),
        .en       (state == ST_BLANK),
        .load_val (blank_q - 1'b1),
        .tc       (blank_tc)
    );

    always_ff @(posedge clk) begin
        if (start_ok) begin
            last_q  <= last;
            dwell_q <= dwell;
            blank_q <= blank;
            cont_q  <= cont;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            dis   <= 1'b1;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state <= ST_ACTIVE;
                        idx   <= '0;
                        dis   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        dis   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (dwell_tc) begin
                        if (at_last && !cont_q) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                            dis   <= 1'b1;
                            busy  <= 1'b0;
                            wrap  <= 1'b1;
                            done  <= 1'b1;
                        end else if (blank_q != '0) begin
                            state <= ST_BLANK;
                            dis   <= 1'b1;
                        end else begin
                            idx  <= next_idx;
                            wrap <= at_last;
                        end
                    end
                end
                ST_BLANK: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else if (blank_tc) begin
                        state <= ST_ACTIVE;
                        idx   <= next_idx;
                        dis   <= 1'b0;
                        wrap  <= at_last;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    dis   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign {sel2, sel1, sel0} = idx;

endmodule

// File: tb/tb_tc_scan_sequencer.sv
// Directed bench for tc_scan_sequencer: a per-run expected-output queue built from the scan rules, checked every cycle.
module tb_tc_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, cont;
    logic [2:0] last;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic       sel0, sel1, sel2, dis, busy, wrap, done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    logic [6:0] exp_q[$];
    logic [6:0] trace[0:1023];

    localparam logic [6:0] IDLE_V = 7'b000_1_0_0_0;

    always #5 clk = ~clk;

    tc_scan_sequencer #(.UUID(7), .NAME("scan0")) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .last  (last),
        .dwell (dwell),
        .blank (blank),
        .sel0  (sel0),
        .sel1  (sel1),
        .sel2  (sel2),
        .dis   (dis),
        .busy  (busy),
        .wrap  (wrap),
        .done  (done)
    );

    wire [6:0] obs = {sel2, sel1, sel0, dis, busy, wrap, done};

    function automatic logic [6:0] mk(input logic [2:0] s, input logic d, input logic b,
                                      input logic w, input logic dn);
        return {s, d, b, w, dn};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got sel=%0d dis=%b busy=%b wrap=%b done=%b, expected sel=%0d dis=%b busy=%b wrap=%b done=%b",
                     name, $time, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] e;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
            check("cycle", obs, e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc < 1023) cyc++;
        trace[cyc] = obs;
    endtask

    // Expected outputs for one run: a leading idle cycle (start not yet sampled), then each index in turn.
    task automatic build(input logic [2:0] l, input logic [7:0] d, input logic [3:0] b,
                         input logic c, input int passes);
        exp_q.push_back(IDLE_V);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i <= int'(l); i++) begin
                for (int k = 0; k <= int'(d); k++)
                    exp_q.push_back(mk(i[2:0], 1'b0, 1'b1,
                                       (p > 0 && i == 0 && k == 0) ? 1'b1 : 1'b0, 1'b0));
                if (b != 4'd0 && !(i == int'(l) && !c))
                    for (int k = 0; k < int'(b); k++)
                        exp_q.push_back(mk(i[2:0], 1'b1, 1'b1, 1'b0, 1'b0));
            end
        end
        if (!c) exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    endtask

    task automatic run(input logic [2:0] l, input logic [7:0] d, input logic [3:0] b, input logic c,
                       input int passes, input int abort_at, input bit by_rst, input bit disturb);
        int guard;
        tick();
        cyc = 0;
        last = l; dwell = d; blank = b; cont = c; start = 1'b1;
        build(l, d, b, c, passes);
        tick();
        if (disturb) begin
            last = ~l; dwell = d + 8'd3; blank = b + 4'd1; cont = ~c;
        end else begin
            start = 1'b0;
        end
        if (abort_at > 0) begin
            while (cyc < abort_at) tick();
            if (by_rst) rst = 1'b1;
            else stop = 1'b1;
            tick();
            rst = 1'b0; stop = 1'b0; start = 1'b0;
            exp_q.delete();
        end else begin
            guard = 0;
            while (exp_q.size() > 0 && guard < 2000) begin
                tick();
                guard++;
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expected cycles left after %0d cycles, required 0", exp_q.size(), guard);
                exp_q.delete();
            end
        end
        tick();
        tick();
    endtask

    initial begin
        int dn_cnt;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        last = 3'd0; dwell = 8'd0; blank = 4'd0;
        tick();
        start = 1'b1; stop = 1'b1;
        tick();
        check("reset", obs, IDLE_V);
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        chk_en = 1'b1;

        // last=3 dwell=1 no blank single pass
        run(3'd3, 8'd1, 4'd0, 1'b0, 1, 0, 1'b0, 1'b0);
        check("r32_c1", trace[1], mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r32_c3", trace[3], mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r32_c8", trace[8], mk(3'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r32_done", trace[9], mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1));
        check("r32_after", trace[10], IDLE_V);

        // blanking between indices, none after last
        run(3'd2, 8'd0, 4'd2, 1'b0, 1, 0, 1'b0, 1'b0);
        check("r33_blank", trace[2], mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        check("r33_idx1", trace[4], mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r33_idx2", trace[7], mk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r33_done", trace[8], mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1));

        // continuous, stopped mid-run
        run(3'd1, 8'd2, 4'd0, 1'b1, 4, 20, 1'b0, 1'b0);
        check("r34_c6", trace[6], mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r34_wrap7", trace[7], mk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        check("r34_wrap13", trace[13], mk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        dn_cnt = 0;
        for (int k = 1; k <= 20; k++) dn_cnt += int'(trace[k][0]);
        checks++;
        if (dn_cnt != 0) begin
            errors++;
            $display("FAIL r34_nodone: done pulses=%0d, required 0", dn_cnt);
        end
        check("r34_stop", trace[21], IDLE_V);

        // stop on the cycle the blank counter expires
        run(3'd2, 8'd0, 4'd2, 1'b0, 1, 3, 1'b0, 1'b0);
        check("r35_blank", trace[3], mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        check("r35_stop", trace[4], IDLE_V);

        // start/settings changes ignored mid-run, then reset in ACTIVE
        run(3'd3, 8'd4, 4'd1, 1'b0, 1, 9, 1'b1, 1'b1);
        check("r36_blank", trace[6], mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        check("r36_idx1", trace[8], mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        check("r36_rst", trace[10], IDLE_V);

        // last=0 single pass skips blanking
        run(3'd0, 8'd0, 4'd3, 1'b0, 1, 0, 1'b0, 1'b0);
        check("l0_done", trace[2], mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1));

        // last=0 continuous with blank: wrap every pass
        run(3'd0, 8'd0, 4'd1, 1'b1, 4, 5, 1'b0, 1'b0);
        check("l0c_wrap3", trace[3], mk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        check("l0c_blank4", trace[4], mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0));

        // maximum dwell
        run(3'd0, 8'd255, 4'd0, 1'b0, 1, 0, 1'b0, 1'b0);
        check("d255_c256", trace[256], mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        check("d255_done", trace[257], mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1));

        // start with stop in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        check("startstop", obs, IDLE_V);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
